// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter
// Brief    : Round-robin arbiter/sequencer sharing one add/sub datapath
//            between two valid/ready requesters; one operation in flight.
// Revision : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
    parameter int WIDTH      = 8,
    parameter int DP_LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic             req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic             req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [WIDTH-1:0] dp_a,
    output logic [WIDTH-1:0] dp_b,
    output logic             dp_sel,
    input  logic [WIDTH-1:0] dp_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
);

    localparam int c_CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_last_grant;
    logic               r_id;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_dp_a;
    logic [WIDTH-1:0]   r_dp_b;
    logic               r_dp_sel;
    logic               r_rsp_valid;
    logic               r_rsp_id;
    logic [WIDTH-1:0]   r_rsp_data;

    logic               w_take;
    logic               w_grant_id;
    logic               w_done;

    // Grant goes to the only valid requester, or to the one not served last.
    always_comb begin
        w_take     = (r_state == S_IDLE) && (req0_valid || req1_valid);
        w_grant_id = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
        w_done     = (r_state == S_BUSY) && (r_cnt == c_CNT_W'(1));
    end

    // Ready is masked by reset so nothing is offered while the block is held.
    assign req0_ready = reset_l && w_take && !w_grant_id;
    assign req1_ready = reset_l && w_take &&  w_grant_id;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_take)    w_state_nxt = S_BUSY;
            S_BUSY:  if (w_done)    w_state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
            default:                w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_cnt        <= '0;
            r_dp_a       <= '0;
            r_dp_b       <= '0;
            r_dp_sel     <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_data   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_id         <= w_grant_id;
                        r_last_grant <= w_grant_id;
                        r_cnt        <= c_CNT_W'(DP_LATENCY);
                        r_dp_sel     <= w_grant_id ? req1_op : req0_op;
                        r_dp_a       <= w_grant_id ? req1_a  : req0_a;
                        r_dp_b       <= w_grant_id ? req1_b  : req0_b;
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt - c_CNT_W'(1);
                    if (w_done) begin
                        r_rsp_data  <= dp_result;
                        r_rsp_id    <= r_id;
                        r_rsp_valid <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign dp_a      = r_dp_a;
    assign dp_b      = r_dp_b;
    assign dp_sel    = r_dp_sel;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_share_arbiter
// Brief    : Directed self-checking bench; DP_LATENCY=3 main instance and a
//            DP_LATENCY=1 instance, both fed by a combinational add/sub model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;

    localparam int W   = 8;
    localparam int LAT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_l;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // main instance (DP_LATENCY = 3)
    logic         req0_valid, req0_ready, req0_op;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready, req1_op;
    logic [W-1:0] req1_a, req1_b;
    logic [W-1:0] dp_a, dp_b, dp_result, rsp_data;
    logic         dp_sel, rsp_valid, rsp_ready, rsp_id, busy;

    // fast instance (DP_LATENCY = 1)
    logic         f_req0_valid, f_req0_ready, f_req0_op;
    logic [W-1:0] f_req0_a, f_req0_b;
    logic         f_req1_ready;
    logic [W-1:0] f_dp_a, f_dp_b, f_dp_result, f_rsp_data;
    logic         f_dp_sel, f_rsp_valid, f_rsp_id, f_busy;

    assign dp_result   = dp_sel   ? (dp_a - dp_b)     : (dp_a + dp_b);
    assign f_dp_result = f_dp_sel ? (f_dp_a - f_dp_b) : (f_dp_a + f_dp_b);

    alu_share_arbiter #(.WIDTH(W), .DP_LATENCY(LAT)) u_dut (
        .clk(clk), .reset_l(reset_l),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .dp_a(dp_a), .dp_b(dp_b), .dp_sel(dp_sel), .dp_result(dp_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .busy(busy)
    );

    alu_share_arbiter #(.WIDTH(W), .DP_LATENCY(1)) u_dut_fast (
        .clk(clk), .reset_l(reset_l),
        .req0_valid(f_req0_valid), .req0_ready(f_req0_ready), .req0_op(f_req0_op),
        .req0_a(f_req0_a), .req0_b(f_req0_b),
        .req1_valid(1'b0), .req1_ready(f_req1_ready), .req1_op(1'b0),
        .req1_a(8'h00), .req1_b(8'h00),
        .dp_a(f_dp_a), .dp_b(f_dp_b), .dp_sel(f_dp_sel), .dp_result(f_dp_result),
        .rsp_valid(f_rsp_valid), .rsp_ready(1'b1), .rsp_id(f_rsp_id),
        .rsp_data(f_rsp_data), .busy(f_busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // contention payloads: id0 = 0xF0+0x20 -> 0x10, id1 = 0x03-0x05 -> 0xFE
    function automatic logic [W-1:0] exp_data(input logic id);
        return id ? 8'hFE : 8'h10;
    endfunction

    function automatic logic [16:0] exp_dp(input logic id);
        return id ? {1'b1, 8'h03, 8'h05} : {1'b0, 8'hF0, 8'h20};
    endfunction

    int           hs_cyc[4];
    logic         hs_id[4];
    int           rsp_cyc[4];
    logic         rsp_id_q[4];
    logic [W-1:0] rsp_data_q[4];
    int           n_hs, n_rsp, pend_cyc, n_seen;
    logic         pend, pend_id, ok;

    initial begin
        reset_l      = 1'b0;
        req0_valid   = 1'b1; req0_op = 1'b0; req0_a = 8'hF0; req0_b = 8'h20;
        req1_valid   = 1'b1; req1_op = 1'b1; req1_a = 8'h03; req1_b = 8'h05;
        rsp_ready    = 1'b1;
        f_req0_valid = 1'b0; f_req0_op = 1'b0; f_req0_a = 8'h00; f_req0_b = 8'h00;

        // reset with both valids high
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              {req0_ready, req1_ready, rsp_valid, rsp_id, busy, dp_sel, dp_a, dp_b, rsp_data}, 32'h0);
        check("reset_fast_outputs",
              {f_req0_ready, f_req1_ready, f_rsp_valid, f_rsp_id, f_busy, f_dp_sel, f_dp_a, f_dp_b, f_rsp_data}, 32'h0);
        @(posedge clk); #1 reset_l = 1'b1;
        @(negedge clk);
        check("first_cycle_ready", {req0_ready, req1_ready}, 2'b10);

        // contention: four back-to-back operations, rsp_ready held high
        n_hs = 0; n_rsp = 0; pend = 1'b0; pend_cyc = 0; pend_id = 1'b0;
        for (int c = 0; c < 80; c++) begin
            if (pend && cyc == pend_cyc) begin
                check("cont_dp_operands", {dp_sel, dp_a, dp_b, busy}, {exp_dp(pend_id), 1'b1});
                pend = 1'b0;
            end
            if (req0_ready && req1_ready) check("cont_ready_exclusive", 1, 0);
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                if (n_hs < 4) begin
                    hs_cyc[n_hs] = cyc;
                    hs_id[n_hs]  = req1_ready;
                end
                pend = 1'b1; pend_cyc = cyc + 1; pend_id = req1_ready;
                n_hs++;
            end
            if (rsp_valid && rsp_ready) begin
                if (n_rsp < 4) begin
                    rsp_cyc[n_rsp]    = cyc;
                    rsp_id_q[n_rsp]   = rsp_id;
                    rsp_data_q[n_rsp] = rsp_data;
                end
                n_rsp++;
            end
            if (n_rsp >= 4) break;
            @(negedge clk);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("cont_rsp_count", n_rsp, 4);
        for (int k = 0; k < 4; k++) begin
            if (k < n_hs && k < n_rsp) begin
                check($sformatf("cont_grant_id_%0d", k), hs_id[k], k % 2);
                if (k > 0) check($sformatf("cont_hs_gap_%0d", k), hs_cyc[k] - hs_cyc[k-1], LAT + 2);
                check($sformatf("cont_rsp_latency_%0d", k), rsp_cyc[k] - hs_cyc[k], LAT + 1);
                check($sformatf("cont_rsp_id_%0d", k), rsp_id_q[k], hs_id[k]);
                check($sformatf("cont_rsp_data_%0d", k), rsp_data_q[k], exp_data(hs_id[k]));
            end
        end

        // backpressure: req0 0x10-0x01 = 0x0F held for 5 cycles
        @(posedge clk); #1;
        rsp_ready  = 1'b0;
        req0_valid = 1'b1; req0_op = 1'b1; req0_a = 8'h10; req0_b = 8'h01;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (req0_ready) begin ok = 1'b1; break; end
        end
        check("bp_grant_seen", ok, 1);
        @(posedge clk); #1 req0_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid) begin ok = 1'b1; break; end
        end
        check("bp_rsp_seen", ok, 1);
        @(posedge clk); #1;
        req1_valid = 1'b1; req1_op = 1'b1; req1_a = 8'h40; req1_b = 8'h41;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp_hold_%0d", i),
                  {rsp_valid, rsp_id, busy, req0_ready, req1_ready, rsp_data},
                  {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h0F});
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_released_idle", {rsp_valid, busy, req0_ready, req1_ready}, 4'b0001);

        // req1 granted at the coming edge; reset one cycle later
        @(posedge clk); #1;
        check("midbusy_busy_before_reset", busy, 1);
        reset_l = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        check("midbusy_reset_outputs",
              {req0_ready, req1_ready, rsp_valid, rsp_id, busy, dp_sel, dp_a, dp_b, rsp_data}, 32'h0);
        repeat (2) @(posedge clk);
        #1 reset_l = 1'b1;
        n_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid) n_seen++;
        end
        check("midbusy_no_response", n_seen, 0);
        check("midbusy_idle_after", busy, 0);
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_op = 1'b0; req0_a = 8'h01; req0_b = 8'h02;
        req1_valid = 1'b1;
        @(negedge clk);
        check("post_reset_contention", {req0_ready, req1_ready}, 2'b10);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (LAT + 3) @(posedge clk);

        // single add on DP_LATENCY=1 instance: 0x05 + 0x03
        #1;
        f_req0_valid = 1'b1; f_req0_op = 1'b0; f_req0_a = 8'h05; f_req0_b = 8'h03;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (f_req0_ready) begin ok = 1'b1; break; end
        end
        check("add_grant_seen", ok, 1);
        @(posedge clk); #1 f_req0_valid = 1'b0;
        @(negedge clk);
        check("add_dp_at_e1", {f_dp_sel, f_dp_a, f_dp_b, f_rsp_valid, f_busy},
              {1'b0, 8'h05, 8'h03, 1'b0, 1'b1});
        @(negedge clk);
        check("add_rsp_at_e2", {f_rsp_valid, f_rsp_id, f_rsp_data}, {1'b1, 1'b0, 8'h08});
        @(negedge clk);
        check("add_rsp_done", {f_rsp_valid, f_busy}, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Round-robin arbiter and sequencer that shares one add/subtract datapath (Adder, Subtractor and result mux) between two requesters. Each requester presents an operation and two operands on a valid/ready handshake. The block grants one requester, drives the shared datapath operands and mux select, and waits a fixed datapath latency. It then returns the result, tagged with the requester id, on a valid/ready response channel. Only one operation is in flight at a time.

## Interface
- WIDTH, 8, operand/result width
- DP_LATENCY, 1, cycles from operands driven on dp_* to dp_result valid; legal range 1..15
- clk  in  1  clock, rising edge
- reset_l  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation pending
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_op  in  1  0 = add (a+b), 1 = subtract (a-b)
- req0_a, req0_b  in  WIDTH  requester 0 operands
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1
- dp_a, dp_b  out  WIDTH  operands to the shared Adder/Subtractor
- dp_sel  out  1  result-mux select: 0 = adder sum, 1 = subtractor diff
- dp_result  in  WIDTH  mux output from the datapath
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester that issued the operation
- rsp_data  out  WIDTH  operation result
- busy  out  1  high whenever the block is not in IDLE

## Operation
- FSM has three states: IDLE, BUSY, RESP.
- IDLE:
  - If no requester is valid, stay in IDLE.
  - If exactly one requester is valid, grant it.
  - If both are valid, grant the requester that was not granted last (last_grant register).
  - Granted reqN_ready = 1 in this cycle, combinationally from state and valids. The other ready = 0.
  - On the handshake edge, latch op/a/b into dp_sel/dp_a/dp_b, latch id, set last_grant = id, load cnt = DP_LATENCY, go to BUSY.
- BUSY:
  - dp_a/dp_b/dp_sel stay held.
  - cnt decrements each cycle.
  - On the edge where cnt == 1: rsp_data <= dp_result, rsp_id <= latched id, go to RESP.
- RESP:
  - rsp_valid = 1. rsp_data and rsp_id are stable until the handshake.
  - On rsp_valid && rsp_ready, go to IDLE. rsp_valid drops the next cycle.
- In BUSY and RESP, both req ready outputs = 0. Requesters must hold valid and payload until ready.
- Arithmetic is performed by the datapath, modulo 2^WIDTH (add wraps, subtract wraps). The block passes dp_result through unmodified.
- Reset (reset_l low, asynchronous, at any time including mid-BUSY or RESP):
  - state = IDLE, last_grant = 1, so requester 0 wins the first contention.
  - All outputs = 0: ready, rsp_valid, rsp_id, rsp_data, dp_a, dp_b, dp_sel, busy.
  - Any in-flight operation is dropped with no response.
- dp_a/dp_b/dp_sel keep their last values in IDLE and RESP.

## Timing
- Handshake at edge E0 (cycle with reqN_valid && reqN_ready).
- dp_* valid from cycle E0+1. busy = 1 from cycle E0+1.
- dp_result sampled at the end of cycle E0+DP_LATENCY.
- rsp_valid first high in cycle E0+DP_LATENCY+1.
- With rsp_ready held high: the response completes in that cycle and the next grant can occur in cycle E0+DP_LATENCY+2.
- Peak throughput: one operation per DP_LATENCY+2 cycles.
- req ready is combinational from registered state plus valids. req valid must not depend on ready.
- rsp_valid, rsp_data and rsp_id are registered outputs.

## Test plan
- Reset: hold reset_l low with both valids high → all outputs 0, no ready. Release reset → req0_ready = 1 in the first cycle.
- Single add (WIDTH=8, DP_LATENCY=1): req0 op=0, a=0x05, b=0x03.
  - Required: dp_sel=0, dp_a=0x05, dp_b=0x03 at E0+1.
  - Required: rsp_valid at E0+2 with rsp_data=0x08, rsp_id=0.
- Subtract wrap (DP_LATENCY=3): req1 op=1, a=0x03, b=0x05.
  - Required: dp_sel=1.
  - Required: rsp_valid at E0+4 with rsp_data=0xFE, rsp_id=1.
- Contention: both valids held high for 4 operations with rsp_ready=1 → grant order 0,1,0,1. Handshakes are exactly DP_LATENCY+2 cycles apart.
- Backpressure: rsp_ready=0 for 5 cycles during RESP → rsp_valid stays 1, rsp_data/rsp_id unchanged, both req ready = 0. Raising rsp_ready completes the response and returns the FSM to IDLE.
- Reset mid-BUSY: assert reset_l low one cycle after a req1 grant → no response is ever issued. After release, contention grants requester 0 first.
